// File: rtl/shift_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shift_pipe_pkg
// Definitions shared by the shift-pipeline scheduler and its stage chain:
//   - scheduler FSM state encodings (ST_IDLE, ST_SHIFT)
//   - requester source IDs (SRC_0, SRC_1)
//   - layout of the per-bit record that travels down the pipeline
//   - round-robin winner selection
// -----------------------------------------------------------------------------
package shift_pipe_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic SRC_0 = 1'b0;
    localparam logic SRC_1 = 1'b1;

    // One pipeline slot: data bit, slot valid, originating requester, and a
    // marker on the final (LSB) bit of a frame.
    typedef struct packed {
        logic dbit;
        logic en;
        logic src;
        logic last;
    } stage_rec_t;

    // Round-robin pick. On a tie the requester that was not served last wins;
    // the caller only uses the result when at least one request is present.
    function automatic logic pick_winner(input logic a_req0,
                                         input logic a_req1,
                                         input logic a_last_src);
        logic w_sel;
        if (a_req0 && a_req1) begin
            w_sel = ~a_last_src;
        end else if (a_req1) begin
            w_sel = SRC_1;
        end else begin
            w_sel = SRC_0;
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/shift_stage_chain.sv
// -----------------------------------------------------------------------------
// shift_stage_chain
// DEPTH-deep register chain carrying stage_rec_t records. Every stage moves
// one slot per clock; stage 0 captures rec_in.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset (clears every stage)
//   rec_in  in   record injected into the first stage
//   rec_out out  record held in the last stage
//   any_en  out  some stage currently holds a valid bit
// -----------------------------------------------------------------------------
module shift_stage_chain
    import shift_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  stage_rec_t rec_in,
    output stage_rec_t rec_out,
    output logic       any_en
);

    stage_rec_t r_stage [DEPTH];

    // NOTE: every stage is reset, not just the valid bits, so that q and
    // out_src read 0 the moment reset asserts, even mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample its
            // predecessor's old value, giving a true shift rather than a
            // fall-through of rec_in to the end of the chain in one clock.
            r_stage[0] <= rec_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign rec_out = r_stage[DEPTH-1];

    always_comb begin
        any_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            any_en = any_en | r_stage[k].en;
        end
    end

endmodule

// File: rtl/shift_pipe_sched.sv
// -----------------------------------------------------------------------------
// shift_pipe_sched
// Round-robin scheduler sharing one serial shift pipeline between two
// parallel-word requesters. A granted word is serialized MSB-first; each bit
// is tagged with its source and the frame's LSB raises frame_done on q.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req0/data0         requester 0 pending flag and frame (held until gnt0)
//   req1/data1         requester 1 pending flag and frame (held until gnt1)
//   gnt0/gnt1          one-cycle combinational accept pulses
//   q                  serial data at the pipeline output
//   out_valid          q carries a frame bit
//   out_src            source of the bit on q
//   frame_done         pulse with the LSB of a frame on q
//   busy               FSM shifting or any pipeline stage valid
// -----------------------------------------------------------------------------
module shift_pipe_sched
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             q,
    output logic             out_valid,
    output logic             out_src,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_src;
    logic               r_last_src;

    logic               w_winner;
    logic               w_last_bit;
    logic               w_grant;
    logic               w_chain_busy;
    stage_rec_t         w_inj;
    stage_rec_t         w_rec_out;

    // Arbitration, grant and next state. Grants are also possible on the
    // final SHIFT cycle so consecutive frames run without a bubble. Grants
    // are masked while reset is held so no requester sees a stray accept.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no
        // latch is inferred.
        w_state_nxt = r_state;
        w_inj       = '0;
        w_winner    = pick_winner(req0, req1, r_last_src);
        w_last_bit  = (r_state == ST_SHIFT) && (r_bitcnt == '0);
        w_grant     = rst_n && (req0 || req1) &&
                      ((r_state == ST_IDLE) || w_last_bit);

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_inj.dbit = r_sreg[WIDTH-1];
                w_inj.en   = 1'b1;
                w_inj.src  = r_src;
                w_inj.last = w_last_bit;
                if (w_last_bit && !w_grant) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt0 = w_grant && (w_winner == SRC_0);
    assign gnt1 = w_grant && (w_winner == SRC_1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word register and bit counter. last_src resets to 1 so requester 0
    // wins the first tie. The counter is only decremented above zero; a
    // reload or the return to IDLE handles the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg     <= '0;
            r_bitcnt   <= '0;
            r_src      <= SRC_0;
            r_last_src <= SRC_1;
        end else if (w_grant) begin
            r_sreg     <= (w_winner == SRC_1) ? data1 : data0;
            r_bitcnt   <= CNT_W'(WIDTH - 1);
            r_src      <= w_winner;
            r_last_src <= w_winner;
        end else if ((r_state == ST_SHIFT) && !w_last_bit) begin
            r_sreg     <= r_sreg << 1;
            r_bitcnt   <= r_bitcnt - CNT_W'(1);
        end
    end

    shift_stage_chain #(
        .DEPTH (DEPTH)
    ) u_chain (
        .clk     (clk),
        .rst_n   (rst_n),
        .rec_in  (w_inj),
        .rec_out (w_rec_out),
        .any_en  (w_chain_busy)
    );

    // Idle stages hold all-zero records, so q and out_src are 0 whenever
    // out_valid is 0 without extra masking.
    assign q          = w_rec_out.dbit;
    assign out_valid  = w_rec_out.en;
    assign out_src    = w_rec_out.src;
    assign frame_done = w_rec_out.en & w_rec_out.last;
    assign busy       = (r_state != ST_IDLE) || w_chain_busy;

endmodule

// File: tb/tb_shift_pipe_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe_sched
// Scoreboard bench for shift_pipe_sched. The stimulus process predicts every
// serial bit (value, source, frame_done, cycle) when it issues a grant and
// queues it; independent monitors pop and compare whenever out_valid is high.
// Two instances: WIDTH=8/DEPTH=2 and WIDTH=4/DEPTH=1.
// -----------------------------------------------------------------------------
module tb_shift_pipe_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8, DEPTH=2 instance
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, q, out_valid, out_src, frame_done, busy;

    // WIDTH=4, DEPTH=1 instance
    logic       r4_req0 = 1'b0, r4_req1 = 1'b0;
    logic [3:0] r4_data0 = '0, r4_data1 = '0;
    logic       g4_0, g4_1, q4, v4, s4, d4, b4;

    shift_pipe_sched #(.WIDTH(8), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .q(q), .out_valid(out_valid),
        .out_src(out_src), .frame_done(frame_done), .busy(busy)
    );

    shift_pipe_sched #(.WIDTH(4), .DEPTH(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(r4_req0), .data0(r4_data0), .req1(r4_req1), .data1(r4_data1),
        .gnt0(g4_0), .gnt1(g4_1), .q(q4), .out_valid(v4),
        .out_src(s4), .frame_done(d4), .busy(b4)
    );

    typedef struct {
        logic q;
        logic src;
        logic done;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    exp_t m_e;
    exp_t m_e4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("dut8 unexpected bit", {31'b0, out_valid}, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("dut8 bit cycle", cyc, m_e.cyc);
                check("dut8 q", {31'b0, q}, {31'b0, m_e.q});
                check("dut8 out_src", {31'b0, out_src}, {31'b0, m_e.src});
                check("dut8 frame_done", {31'b0, frame_done}, {31'b0, m_e.done});
            end
        end else begin
            check("dut8 idle outputs", {29'b0, q, out_src, frame_done}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (v4 === 1'b1) begin
            if (sb4.size() == 0) begin
                check("dut4 unexpected bit", {31'b0, v4}, 32'd0);
            end else begin
                m_e4 = sb4.pop_front();
                check("dut4 bit cycle", cyc, m_e4.cyc);
                check("dut4 q", {31'b0, q4}, {31'b0, m_e4.q});
                check("dut4 out_src", {31'b0, s4}, {31'b0, m_e4.src});
                check("dut4 frame_done", {31'b0, d4}, {31'b0, m_e4.done});
            end
        end else begin
            check("dut4 idle outputs", {29'b0, q4, s4, d4}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_gnt(input logic e0, input logic e1, input string tag);
        #1;
        check({tag, " gnt0"}, {31'b0, gnt0}, {31'b0, e0});
        check({tag, " gnt1"}, {31'b0, gnt1}, {31'b0, e1});
    endtask

    // Expected serial stream of an 8-bit frame granted in cycle t_gnt:
    // bit i (MSB first) on q in cycle t_gnt + 1 + i + DEPTH.
    task automatic push_frame8(input logic [7:0] w, input logic src, input int t_gnt);
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{q: w[7-i], src: src, done: (i == 7), cyc: t_gnt + 3 + i});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gnt"}, {30'b0, gnt0, gnt1}, 32'd0);
        check({tag, " q"}, {31'b0, q}, 32'd0);
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, " out_src"}, {31'b0, out_src}, 32'd0);
        check({tag, " frame_done"}, {31'b0, frame_done}, 32'd0);
        check({tag, " busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || b4 || sb.size() != 0 || sb4.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check({tag, " drained busy"}, {30'b0, busy, b4}, 32'd0);
    endtask

    initial begin
        int t;

        // Reset held with random requests: everything stays quiet.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req0  = 1'($urandom_range(0, 1));
            req1  = 1'($urandom_range(0, 1));
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            #1;
            check_reset_outputs("reset hold");
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Single frame 0xA5 from requester 0.
        req0  = 1'b1;
        data0 = 8'hA5;
        settle_gnt(1'b1, 1'b0, "t1 grant");
        t = cyc;
        push_frame8(8'hA5, 1'b0, t);
        tick();
        req0 = 1'b0;
        settle_gnt(1'b0, 1'b0, "t1 after grant");
        while (cyc < t + 10) tick();
        #1;
        check("t1 busy at LSB", {31'b0, busy}, 32'd1);
        tick();
        #1;
        check("t1 busy after frame", {31'b0, busy}, 32'd0);

        // Both requesters from reset: 0 first, then 1 back-to-back.
        tick();
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'hF0;
        data1 = 8'h0F;
        #1;
        check_reset_outputs("t2 reset");
        tick();
        rst_n = 1'b1;
        settle_gnt(1'b1, 1'b0, "t2 first grant");
        t = cyc;
        push_frame8(8'hF0, 1'b0, t);
        for (int k = 1; k < 8; k++) begin
            tick();
            settle_gnt(1'b0, 1'b0, "t2 mid frame");
        end
        tick();
        settle_gnt(1'b0, 1'b1, "t2 second grant");
        push_frame8(8'h0F, 1'b1, cyc);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        settle_gnt(1'b0, 1'b0, "t2 after");
        wait_idle("t2");

        // Four frames with both requests held: grants alternate 0,1,0,1.
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h3C;
        data1 = 8'hC3;
        for (int f = 0; f < 4; f++) begin
            settle_gnt(f % 2 == 0, f % 2 == 1, "t3 grant");
            push_frame8((f % 2 == 0) ? 8'h3C : 8'hC3, 1'(f % 2), cyc);
            if (f < 3) begin
                for (int k = 1; k < 8; k++) begin
                    tick();
                    settle_gnt(1'b0, 1'b0, "t3 mid frame");
                end
                tick();
            end
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle("t3");

        // Async reset while bit 3 of a requester-1 frame is on q.
        req1  = 1'b1;
        data1 = 8'h96;
        settle_gnt(1'b0, 1'b1, "t4 grant");
        t = cyc;
        push_frame8(8'h96, 1'b1, t);
        tick();
        req1 = 1'b0;
        while (cyc < t + 6) tick();
        rst_n = 1'b0;
        sb.delete();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h5A;
        data1 = 8'h96;
        #1;
        check_reset_outputs("t4 async reset");
        tick();
        #1;
        check_reset_outputs("t4 reset held");
        tick();
        rst_n = 1'b1;
        settle_gnt(1'b1, 1'b0, "t4 first after reset");
        t = cyc;
        push_frame8(8'h5A, 1'b0, t);
        tick();
        req0 = 1'b0;
        settle_gnt(1'b0, 1'b0, "t4 after grant0");
        while (cyc < t + 8) tick();
        settle_gnt(1'b0, 1'b1, "t4 requester1 restart");
        push_frame8(8'h96, 1'b1, cyc);
        tick();
        req1 = 1'b0;
        wait_idle("t4");

        // WIDTH=4, DEPTH=1: 4'b1001 from requester 1, MSB at T+2.
        r4_req1  = 1'b1;
        r4_data1 = 4'b1001;
        #1;
        check("t5 gnt1", {31'b0, g4_1}, 32'd1);
        check("t5 gnt0", {31'b0, g4_0}, 32'd0);
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            sb4.push_back('{q: r4_data1[3-i], src: 1'b1, done: (i == 3), cyc: t + 2 + i});
        end
        tick();
        r4_req1 = 1'b0;
        #1;
        check("t5 gnt1 after", {31'b0, g4_1}, 32'd0);
        wait_idle("t5");

        tick();
        check("dut8 scoreboard drained", sb.size(), 32'd0);
        check("dut4 scoreboard drained", sb4.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pipe_sched.md
Name: shift_pipe_sched

Overview:
- Round-robin scheduler that shares one serial two-flop shift pipeline (d -> n1 -> q style, non-blocking stages) between two parallel-word requesters.
- Arbitrates between requesters and latches the granted word.
- Serializes the word MSB-first into the pipeline and tags every output bit with its source.
- Sits between parallel producers and the serial shift datapath.

Parameters:
- WIDTH, 8, bits per frame (>=2)
- DEPTH, 2, number of pipeline register stages between serial injection and q (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 has a frame pending
- data0  in  WIDTH  requester 0 frame; held stable while req0=1 until gnt0
- req1  in  1  requester 1 has a frame pending
- data1  in  WIDTH  requester 1 frame; held stable while req1=1 until gnt1
- gnt0  out  1  one-cycle accept pulse for requester 0
- gnt1  out  1  one-cycle accept pulse for requester 1
- q  out  1  serial data at pipeline output
- out_valid  out  1  q carries a frame bit this cycle
- out_src  out  1  source of the bit on q (0/1)
- frame_done  out  1  pulse coincident with the LSB of a frame on q
- busy  out  1  state!=IDLE or any pipeline stage valid

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. Reset clears every flop immediately, including mid-frame.
- Reset values: all outputs 0; state=IDLE; last_src=1, so req0 wins the first tie.
- FSM has two states, IDLE and SHIFT.
  - IDLE: if req0|req1, assert the selected gnt combinationally in that cycle. At the clock edge: latch the word into sreg, src<=winner, last_src<=winner, bitcnt<=WIDTH-1, go to SHIFT. Otherwise remain in IDLE.
  - SHIFT: each cycle inject {bit=sreg[WIDTH-1], en=1, src, last=(bitcnt==0)} into pipeline stage 1; sreg<<=1; bitcnt--.
  - On the last bit (bitcnt==0): if any req, grant in the same cycle, reload sreg, stay in SHIFT. This gives back-to-back frames with no bubble. Otherwise go to IDLE.
- Arbitration:
  - Only one req: grant it.
  - Both req: grant the requester != last_src.
  - gnt is only ever asserted in IDLE or on the last SHIFT cycle, and at most one gnt is high per cycle.
  - A req deasserted before its grant is simply never granted; there is no abort.
- Pipeline:
  - DEPTH stages, each carrying {bit, en, src, last}, updated every cycle with non-blocking semantics. Stage k takes stage k-1; stage 1 takes the injection, or zeros when not in SHIFT.
  - q/out_valid/out_src = last-stage bit/en/src; frame_done = last-stage en&last.
- Latency: with gnt in cycle T, frame bit i (MSB=0) appears on q in cycle T+1+i+DEPTH. For DEPTH=2: MSB at T+3, LSB at T+WIDTH+2.
- When out_valid=0: q=0, out_src=0.
- Counter width: $clog2(WIDTH). No wrap-around beyond reload; bitcnt never underflows.

Decomposition:
- Shared package/include shift_pipe_pkg holds:
  - state encodings ST_IDLE, ST_SHIFT
  - source IDs SRC_0=0, SRC_1=1
  - the stage-record field layout (bit/en/src/last)
- One sub-module, shift_stage_chain: DEPTH-deep register chain of 4-bit records, async active-low reset, input rec_in, output rec_out. The scheduler contains only the FSM, arbiter, sreg and bitcnt.

Test Plan:
- rst_n=0 with random req/data -> gnt0=gnt1=q=out_valid=out_src=frame_done=busy=0. Assert rst_n mid-stream -> same values in the same cycle, without waiting for a clock edge.
- After reset, req0=1, data0=8'hA5 at cycle T -> gnt0=1 in T only. q over T+3..T+10 = 1,0,1,0,0,1,0,1; out_valid=1 and out_src=0 throughout; frame_done=1 only at T+10; busy falls at T+11.
- req0=req1=1 from reset with data0=8'hF0, data1=8'h0F held -> gnt0 at T, gnt1 at T+8. out_valid continuous T+3..T+18; q=11110000_00001111; out_src=0 for 8 cycles then 1; frame_done at T+10 and T+18.
- req0, req1 held high for 4 frames -> grants alternate 0,1,0,1 with no idle cycle between frames.
- rst_n pulsed low during bit 3 of a req1 frame, then released with req0=req1=1 -> all outputs 0; the first grant after reset is gnt0; frame restarts from MSB.
- DEPTH=1, WIDTH=4, req1 with data1=4'b1001 at T -> q at T+2..T+5 = 1,0,0,1; frame_done at T+5.
